fifo_push_arbiter: RTL and testbench

- Shares one sync FIFO write port between NUM_REQ valid/ready source streams.
- Round-robin arbitration with an optional packet lock, so multi-beat packets are never interleaved.
- Tags every pushed word with the source index.
- Sits between the producers and the FIFO: drives the FIFO's push and data, consumes its full flag.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/fifo_push_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
// rr_next is a plain scan-based reference for the round-robin pick.
package fifo_arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Returns {found, index}: the first set bit of req scanning from ptr+1 upward, modulo n.
    function automatic logic [4:0] rr_next(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic [4:0] res;
        int         idx;
        res = '0;
        for (int i = n; i >= 1; i--) begin
            idx = (int'(ptr) + i) % n;
            if (req[idx]) res = {1'b1, 4'(idx)};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: double-width masked priority encoder plus the rr_ptr register.
// The pointer holds the last winner, so the search starts one position above it.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [N-1:0] req_i,
    input  logic         update_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;

    always_comb begin
        for (int i = 0; i < N; i++) mask[i] = (i > int'(ptr_q));
        // Low half: requesters above the pointer; high half: everyone, for the wrap-around.
        dbl   = {req_i, req_i & mask};
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (dbl[j] && !any_o) begin
                any_o = 1'b1;
                if (j >= N) begin
                    idx_o        = W'(j - N);
                    gnt_o[j - N] = 1'b1;
                end else begin
                    idx_o    = W'(j);
                    gnt_o[j] = 1'b1;
                end
            end
        end
        ptr_d = update_i ? idx_o : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) ptr_q <= W'(N - 1);
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO write port between NUM_REQ valid/ready sources, tagging each word with its source id.
//   state | meaning
//   IDLE  | round-robin among valid requesters, one beat per grant
//   LOCK  | owner holds the port until it delivers a beat with last
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int PACKET_MODE = 1,
    parameter int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [NUM_REQ-1:0]             s_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_data_i,
    input  logic [NUM_REQ-1:0]             s_last_i,
    output logic [NUM_REQ-1:0]             s_ready_o,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_o,
    output logic                           fifo_push_o,
    input  logic                           fifo_full_i,
    output logic [ID_WIDTH-1:0]            grant_id_o,
    output logic                           locked_o
);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [ID_WIDTH-1:0]   arb_idx;
    logic                  arb_any;
    logic                  rr_update;
    logic                  active;
    logic [ID_WIDTH-1:0]   sel_idx;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign data_arr[k] = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N (NUM_REQ),
        .W (ID_WIDTH)
    ) u_rr (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .req_i    (s_valid_i),
        .update_i (rr_update),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_id_d = grant_id_q;
        s_ready_o  = '0;
        rr_update  = 1'b0;
        // Ready is gated by reset so an asserted rstn_i silences the port immediately.
        active     = rstn_i && !fifo_full_i;
        sel_idx    = (state_q == LOCK) ? owner_q : arb_idx;
        unique case (state_q)
            IDLE: begin
                if (active && arb_any) begin
                    s_ready_o  = arb_gnt;
                    rr_update  = 1'b1;
                    grant_id_d = arb_idx;
                    if ((PACKET_MODE != 0) && !s_last_i[arb_idx]) begin
                        owner_d = arb_idx;
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (active) begin
                    s_ready_o[owner_q] = 1'b1;
                    if (s_valid_i[owner_q] && s_last_i[owner_q]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_push_o = |(s_valid_i & s_ready_o);
    assign fifo_data_o = {sel_idx, data_arr[sel_idx]};
    assign grant_id_o  = grant_id_q;
    assign locked_o    = (state_q == LOCK);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            grant_id_q <= grant_id_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench: hand-derived vector table, corner sequences, and a random run against a queue-free reference model.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    s_valid, s_last;
    logic [N*DW-1:0] s_data;
    logic            full;
    logic [N-1:0]    rdy,    rdy_np;
    logic [IW+DW-1:0] fdata, fdata_np;
    logic            push,   push_np;
    logic [IW-1:0]   gid,    gid_np;
    logic            lck,    lck_np;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PACKET_MODE(1)) dut (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
        .s_ready_o(rdy), .fifo_data_o(fdata), .fifo_push_o(push), .fifo_full_i(full),
        .grant_id_o(gid), .locked_o(lck)
    );

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PACKET_MODE(0)) dut_np (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
        .s_ready_o(rdy_np), .fifo_data_o(fdata_np), .fifo_push_o(push_np), .fifo_full_i(full),
        .grant_id_o(gid_np), .locked_o(lck_np)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fixed_data();
        for (int k = 0; k < N; k++) s_data[k*DW +: DW] = 32'hD000_0000 + 32'(k);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_valid = '1; s_last = '1; full = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 64'(rdy), 64'h0);
        check("rst_push", 64'(push), 64'h0);
        check("rst_locked", 64'(lck), 64'h0);
        check("rst_gid", 64'(gid), 64'h0);
        s_valid = '0; s_last = '0;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  last;
        logic          full;
        logic [N-1:0]  rdy;
        logic          push;
        logic [IW-1:0] pid;
        logic          lck;
        logic [IW-1:0] gid;
    } vec_t;

    vec_t tv [22];

    // Reference model state for the random phase.
    bit   m_lock;
    int   m_owner, m_ptr, m_gid;

    initial begin
        rstn = 1'b0; s_valid = '0; s_last = '0; full = 1'b0; s_data = '0;
        set_fixed_data();

        //        valid  last  full  rdy  push pid lck gid
        tv[0]  = '{4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 2'd0};
        tv[1]  = '{4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1, 1'b0, 2'd0};
        tv[2]  = '{4'hF, 4'hF, 1'b0, 4'h4, 1'b1, 2'd2, 1'b0, 2'd1};
        tv[3]  = '{4'hF, 4'hF, 1'b0, 4'h8, 1'b1, 2'd3, 1'b0, 2'd2};
        tv[4]  = '{4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 2'd3};
        tv[5]  = '{4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1, 1'b0, 2'd0};
        tv[6]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 2'd1};
        tv[7]  = '{4'h7, 4'h5, 1'b0, 4'h2, 1'b1, 2'd1, 1'b0, 2'd0};
        tv[8]  = '{4'h7, 4'h5, 1'b0, 4'h2, 1'b1, 2'd1, 1'b1, 2'd1};
        tv[9]  = '{4'h7, 4'h7, 1'b0, 4'h2, 1'b1, 2'd1, 1'b1, 2'd1};
        tv[10] = '{4'h5, 4'h5, 1'b0, 4'h4, 1'b1, 2'd2, 1'b0, 2'd1};
        tv[11] = '{4'h9, 4'h1, 1'b0, 4'h8, 1'b1, 2'd3, 1'b0, 2'd2};
        tv[12] = '{4'h1, 4'h1, 1'b0, 4'h8, 1'b0, 2'd0, 1'b1, 2'd3};
        tv[13] = '{4'h1, 4'h1, 1'b0, 4'h8, 1'b0, 2'd0, 1'b1, 2'd3};
        for (int i = 14; i < 19; i++)
            tv[i] = '{4'h9, 4'h1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 2'd3};
        tv[19] = '{4'h9, 4'h1, 1'b0, 4'h8, 1'b1, 2'd3, 1'b1, 2'd3};
        tv[20] = '{4'h9, 4'h9, 1'b0, 4'h8, 1'b1, 2'd3, 1'b1, 2'd3};
        tv[21] = '{4'h9, 4'h9, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 2'd3};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            s_valid = tv[i].valid; s_last = tv[i].last; full = tv[i].full;
            @(negedge clk);
            check($sformatf("tv%0d_ready", i), 64'(rdy), 64'(tv[i].rdy));
            check($sformatf("tv%0d_push", i), 64'(push), 64'(tv[i].push));
            check($sformatf("tv%0d_locked", i), 64'(lck), 64'(tv[i].lck));
            check($sformatf("tv%0d_gid", i), 64'(gid), 64'(tv[i].gid));
            if (tv[i].push) begin
                check($sformatf("tv%0d_tag", i), 64'(fdata[DW +: IW]), 64'(tv[i].pid));
                check($sformatf("tv%0d_payload", i), 64'(fdata[DW-1:0]), 64'(32'hD000_0000 + 32'(tv[i].pid)));
            end
            @(posedge clk); #1;
        end

        // Re-arbitrate every beat when packet mode is off.
        do_reset();
        s_valid = 4'h3; s_last = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("np%0d_push", i), 64'(push_np), 64'h1);
            check($sformatf("np%0d_tag", i), 64'(fdata_np[DW +: IW]), 64'(i % 2));
            check($sformatf("np%0d_locked", i), 64'(lck_np), 64'h0);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a locked packet.
        do_reset();
        s_valid = 4'h4; s_last = 4'h0;
        @(posedge clk); #1;
        check("ar_locked_before", 64'(lck), 64'h1);
        #3 rstn = 1'b0;
        #1;
        check("ar_ready", 64'(rdy), 64'h0);
        check("ar_push", 64'(push), 64'h0);
        check("ar_locked", 64'(lck), 64'h0);
        s_valid = 4'hF; s_last = 4'hF;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("ar_first_ready", 64'(rdy), 64'h1);
        check("ar_first_tag", 64'(fdata[DW +: IW]), 64'h0);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        do_reset();
        m_lock = 1'b0; m_owner = 0; m_ptr = N - 1; m_gid = 0;
        s_valid = '0;
        begin
            logic [N-1:0] acc;
            logic [N-1:0] exp_rdy;
            logic         exp_push;
            int           cand;
            bit           found;
            acc = '0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                for (int k = 0; k < N; k++) begin
                    if (!(s_valid[k] && !acc[k])) begin
                        s_valid[k] = ($urandom_range(0, 9) < 6);
                        s_last[k]  = $urandom_range(0, 1) == 1;
                        s_data[k*DW +: DW] = $urandom;
                    end
                end
                full = ($urandom_range(0, 4) == 0);
                @(negedge clk);
                cand = -1;
                found = 1'b0;
                if (m_lock) cand = m_owner;
                else begin
                    for (int i = 1; i <= N; i++) begin
                        if (!found && s_valid[(m_ptr + i) % N]) begin
                            cand  = (m_ptr + i) % N;
                            found = 1'b1;
                        end
                    end
                end
                exp_rdy = '0;
                if (!full && cand >= 0) exp_rdy[cand] = 1'b1;
                exp_push = |(exp_rdy & s_valid);
                check("rnd_ready", 64'(rdy), 64'(exp_rdy));
                check("rnd_push", 64'(push), 64'(exp_push));
                check("rnd_locked", 64'(lck), 64'(m_lock));
                check("rnd_gid", 64'(gid), 64'(m_gid));
                if (exp_push)
                    check("rnd_data", 64'(fdata), 64'({2'(cand), s_data[cand*DW +: DW]}));
                acc = exp_rdy & s_valid;
                if (exp_push) begin
                    m_gid = cand;
                    if (!m_lock) begin
                        m_ptr = cand;
                        if (!s_last[cand]) begin
                            m_lock  = 1'b1;
                            m_owner = cand;
                        end
                    end else if (s_last[cand]) begin
                        m_lock = 1'b0;
                    end
                end
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
